// File: rtl/calc_kl_pkg.sv
// ============================================================================
// Module      : calc_kl_pkg
// Description : Shared position codes, base encoding, widths and FSM states
//               for the k/l interval update stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_kl_pkg;

    localparam int PARAM_W = 8;
    localparam int POS_W   = 5;
    localparam int ADDR_W  = 12;
    localparam int READ_W  = 2;
    localparam int BASE_W  = 2;
    localparam int ROM_AW  = BASE_W + PARAM_W;

    // Lookup codes are laid out so that position[1:0] is the base
    localparam logic [POS_W-1:0] POS_NONE        = 5'd0;
    localparam logic [POS_W-1:0] POS_STOP_1      = 5'd1;
    localparam logic [POS_W-1:0] POS_STOP_2      = 5'd2;
    localparam logic [POS_W-1:0] POS_A_MATCH     = 5'd4;
    localparam logic [POS_W-1:0] POS_C_MATCH     = 5'd5;
    localparam logic [POS_W-1:0] POS_G_MATCH     = 5'd6;
    localparam logic [POS_W-1:0] POS_T_MATCH     = 5'd7;
    localparam logic [POS_W-1:0] POS_A_SNP       = 5'd8;
    localparam logic [POS_W-1:0] POS_C_SNP       = 5'd9;
    localparam logic [POS_W-1:0] POS_G_SNP       = 5'd10;
    localparam logic [POS_W-1:0] POS_T_SNP       = 5'd11;
    localparam logic [POS_W-1:0] POS_A_INSERTION = 5'd12;
    localparam logic [POS_W-1:0] POS_C_INSERTION = 5'd13;
    localparam logic [POS_W-1:0] POS_G_INSERTION = 5'd14;
    localparam logic [POS_W-1:0] POS_T_INSERTION = 5'd15;
    localparam logic [POS_W-1:0] POS_A_DELETION  = 5'd16;
    localparam logic [POS_W-1:0] POS_C_DELETION  = 5'd17;
    localparam logic [POS_W-1:0] POS_G_DELETION  = 5'd18;
    localparam logic [POS_W-1:0] POS_T_DELETION  = 5'd19;

    typedef enum logic [BASE_W-1:0] {
        BASE_A = 2'b00,
        BASE_C = 2'b01,
        BASE_G = 2'b10,
        BASE_T = 2'b11
    } base_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_K = 3'd1,
        ST_RD_L = 3'd2,
        ST_CALC = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    function automatic logic is_lookup(input logic [POS_W-1:0] pos);
        return (pos >= POS_A_INSERTION) && (pos <= POS_T_DELETION);
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_kl_kl_adder.sv
// ============================================================================
// Module      : kl_adder
// Description : Combinational k' = C + O_k + 1, l' = C + O_l with a 9-bit
//               compare flagging an empty interval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kl_adder
    import calc_kl_pkg::*;
(
    input  logic [PARAM_W-1:0] c_i,
    input  logic [PARAM_W-1:0] ok_i,
    input  logic [PARAM_W-1:0] ol_i,
    output logic [PARAM_W-1:0] k_o,
    output logic [PARAM_W-1:0] l_o,
    output logic               empty_o
);

    logic [PARAM_W:0] k_sum;
    logic [PARAM_W:0] l_sum;

    // Carry bit kept so the emptiness test is not fooled by 8-bit wrap
    assign k_sum   = {1'b0, c_i} + {1'b0, ok_i} + 9'd1;
    assign l_sum   = {1'b0, c_i} + {1'b0, ol_i};
    assign empty_o = (k_sum > l_sum);
    assign k_o     = k_sum[PARAM_W-1:0];
    assign l_o     = l_sum[PARAM_W-1:0];

endmodule

`default_nettype wire

// File: rtl/calc_kl.sv
// ============================================================================
// Module      : calc_kl
// Description : k/l suffix-interval update using the occurrence ROM for
//               insertion/deletion positions; other positions pass through.
//               Optional macro CALC_KL_SKIP_EMPTY_EN bypasses ROM reads for
//               lookups whose input interval is already empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_kl
    import calc_kl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [POS_W-1:0]   position,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [PARAM_W-1:0] i_in,
    input  logic [PARAM_W-1:0] z_in,
    input  logic [PARAM_W-1:0] k_in,
    input  logic [PARAM_W-1:0] l_in,
    input  logic [PARAM_W-1:0] d_i_in,
    input  logic [READ_W-1:0]  read_i_in,
    input  logic [PARAM_W-1:0] C_in,
    output logic               ce_rom_O,
    output logic [ROM_AW-1:0]  addr_rom_O,
    input  logic [PARAM_W-1:0] data_rom_O,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [POS_W-1:0]   position_out,
    output logic [ADDR_W-1:0]  addr_out,
    output logic [PARAM_W-1:0] i_out,
    output logic [PARAM_W-1:0] z_out,
    output logic [PARAM_W-1:0] k_out,
    output logic [PARAM_W-1:0] l_out,
    output logic [PARAM_W-1:0] d_i_out,
    output logic [READ_W-1:0]  read_i_out,
    output logic               empty_out
);

    state_e             state_q, state_d;
    logic [POS_W-1:0]   position_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [PARAM_W-1:0] i_q, z_q, k_q, l_q, d_i_q, c_q, ok_q;
    logic [READ_W-1:0]  read_i_q;
    logic               empty_q;

    logic               w_skip;
    logic [BASE_W-1:0]  w_base;
    logic [PARAM_W-1:0] w_k_prev;
    logic [PARAM_W-1:0] w_k_new, w_l_new;
    logic               w_empty_new;

`ifdef CALC_KL_SKIP_EMPTY_EN
    assign w_skip = (k_in > l_in);
`else
    assign w_skip = 1'b0;
`endif

    assign w_base   = position_q[BASE_W-1:0];
    assign w_k_prev = k_q - 8'd1;

    kl_adder u_kl_adder (
        .c_i     (c_q),
        .ok_i    (ok_q),
        .ol_i    (data_rom_O),
        .k_o     (w_k_new),
        .l_o     (w_l_new),
        .empty_o (w_empty_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        ce_rom_O   = 1'b0;
        addr_rom_O = '0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (is_lookup(position) && !w_skip) ? ST_RD_K : ST_OUT;
                end
            end
            ST_RD_K: begin
                // O(base,-1) is defined as 0, so k==0 needs no ROM read
                if (k_q != '0) begin
                    ce_rom_O   = 1'b1;
                    addr_rom_O = {w_base, w_k_prev};
                end
                state_d = ST_RD_L;
            end
            ST_RD_L: begin
                ce_rom_O   = 1'b1;
                addr_rom_O = {w_base, l_q};
                state_d    = ST_CALC;
            end
            ST_CALC: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst) begin
            state_d    = ST_IDLE;
            in_ready   = 1'b0;
            ce_rom_O   = 1'b0;
            addr_rom_O = '0;
            out_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            position_q <= '0;
            addr_q     <= '0;
            i_q        <= '0;
            z_q        <= '0;
            k_q        <= '0;
            l_q        <= '0;
            d_i_q      <= '0;
            read_i_q   <= '0;
            c_q        <= '0;
            ok_q       <= '0;
            empty_q    <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && in_valid) begin
                position_q <= position;
                addr_q     <= addr;
                i_q        <= i_in;
                z_q        <= z_in;
                k_q        <= k_in;
                l_q        <= l_in;
                d_i_q      <= d_i_in;
                read_i_q   <= read_i_in;
                c_q        <= C_in;
                empty_q    <= (k_in > l_in);
            end
            if (state_q == ST_RD_L) begin
                ok_q <= (k_q == '0) ? '0 : data_rom_O;
            end
            if (state_q == ST_CALC) begin
                k_q     <= w_k_new;
                l_q     <= w_l_new;
                empty_q <= w_empty_new;
            end
        end
    end

    assign position_out = position_q;
    assign addr_out     = addr_q;
    assign i_out        = i_q;
    assign z_out        = z_q;
    assign k_out        = k_q;
    assign l_out        = l_q;
    assign d_i_out      = d_i_q;
    assign read_i_out   = read_i_q;
    assign empty_out    = empty_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_kl.sv
// ============================================================================
// Module      : tb_calc_kl
// Description : Self-checking bench for calc_kl against an arithmetic model
//               of the interval update and a behavioural occurrence ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_kl;
    import calc_kl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  position;
    logic [11:0] addr;
    logic [7:0]  i_in, z_in, k_in, l_in, d_i_in, C_in;
    logic [1:0]  read_i_in;
    logic        ce_rom_O;
    logic [9:0]  addr_rom_O;
    logic [7:0]  data_rom_O;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  position_out;
    logic [11:0] addr_out;
    logic [7:0]  i_out, z_out, k_out, l_out, d_i_out;
    logic [1:0]  read_i_out;
    logic        empty_out;

    logic [7:0]  rom [1024];
    int          n_total = 0;
    int          n_pass  = 0;

`ifdef CALC_KL_SKIP_EMPTY_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    calc_kl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .position     (position),
        .addr         (addr),
        .i_in         (i_in),
        .z_in         (z_in),
        .k_in         (k_in),
        .l_in         (l_in),
        .d_i_in       (d_i_in),
        .read_i_in    (read_i_in),
        .C_in         (C_in),
        .ce_rom_O     (ce_rom_O),
        .addr_rom_O   (addr_rom_O),
        .data_rom_O   (data_rom_O),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .position_out (position_out),
        .addr_out     (addr_out),
        .i_out        (i_out),
        .z_out        (z_out),
        .k_out        (k_out),
        .l_out        (l_out),
        .d_i_out      (d_i_out),
        .read_i_out   (read_i_out),
        .empty_out    (empty_out)
    );

    // Occurrence ROM: one-cycle read latency, garbage when not enabled
    always @(posedge clk) begin
        data_rom_O <= ce_rom_O ? rom[addr_rom_O] : 8'($urandom);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic scramble_inputs();
        position  = 5'($urandom);
        addr      = 12'($urandom);
        i_in      = 8'($urandom);
        z_in      = 8'($urandom);
        k_in      = 8'($urandom);
        l_in      = 8'($urandom);
        d_i_in    = 8'($urandom);
        read_i_in = 2'($urandom);
        C_in      = 8'($urandom);
    endtask

    // Runs one operation; called at posedge+1 with the DUT idle
    task automatic run_op(input logic [4:0] pos, input logic [7:0] k, input logic [7:0] l,
                          input logic [7:0] c, input int stall,
                          output logic [7:0] k_res, output logic [7:0] l_res, output logic e_res);
        logic [11:0] a;
        logic [7:0]  ii, zz, dd, ok, ol, ek, el, km1;
        logic [1:0]  rr, b;
        logic [9:0]  exp_addr[$];
        logic [9:0]  got_addr[$];
        int          ks, ls, exp_lat, lat, cyc;
        bit          lookup, ee, stable;

        a = 12'($urandom); ii = 8'($urandom); zz = 8'($urandom);
        dd = 8'($urandom); rr = 2'($urandom);
        b = pos[1:0];
        lookup = (pos >= 5'd12) && (pos <= 5'd19);
        if (lookup && !(SKIP_EN && (k > l))) begin
            km1 = k - 8'd1;
            ok  = (k == 8'd0) ? 8'd0 : rom[{b, km1}];
            ol  = rom[{b, l}];
            ks  = int'(c) + int'(ok) + 1;
            ls  = int'(c) + int'(ol);
            ek  = 8'(ks);
            el  = 8'(ls);
            ee  = (ks > ls);
            exp_lat = 4;
            if (k != 8'd0) exp_addr.push_back({b, km1});
            exp_addr.push_back({b, l});
        end else begin
            ek = k; el = l; ee = (k > l); exp_lat = 1;
        end

        position = pos; addr = a; i_in = ii; z_in = zz; k_in = k; l_in = l;
        d_i_in = dd; read_i_in = rr; C_in = c; in_valid = 1'b1; out_ready = 1'b0;
        check_val("in_ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();

        lat = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (ce_rom_O) got_addr.push_back(addr_rom_O);
            if (out_valid) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("latency", lat, exp_lat);
        check_val("rom_reads", got_addr.size(), exp_addr.size());
        for (int j = 0; j < exp_addr.size() && j < got_addr.size(); j++)
            check_val("rom_addr", got_addr[j], exp_addr[j]);
        check_val("k_out", k_out, ek);
        check_val("l_out", l_out, el);
        check_val("empty_out", empty_out, ee);
        check_val("position_out", position_out, pos);
        check_val("addr_out", addr_out, a);
        check_val("i_z_d_read_out", {i_out, z_out, d_i_out, read_i_out}, {ii, zz, dd, rr});
        check_val("in_ready_in_out", in_ready, 0);

        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (!out_valid || k_out !== ek || l_out !== el || empty_out !== ee ||
                addr_out !== a || in_ready !== 1'b0) stable = 1'b0;
        end
        if (stall > 0) check_val("stall_stable", stable, 1);

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("out_valid_after_hs", out_valid, 0);
        check_val("in_ready_after_hs", in_ready, 1);
        k_res = k_out; l_res = l_out; e_res = empty_out;
    endtask

    initial begin
        logic [7:0] kr, lr;
        logic       er;
        logic [4:0] p;
        logic [7:0] kk, ll;
        bit         seen;

        for (int j = 0; j < 1024; j++) rom[j] = 8'($urandom);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        scramble_inputs();

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_ce_rom", ce_rom_O, 0);
        check_val("rst_outputs", {position_out, addr_out, k_out, l_out, i_out, empty_out}, 0);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // C_DELETION worked example
        rom[10'h104] = 8'd3; rom[10'h109] = 8'd6;
        run_op(POS_C_DELETION, 8'd5, 8'd9, 8'd10, 0, kr, lr, er);
        check_val("ex1_k", kr, 14);
        check_val("ex1_l", lr, 16);
        check_val("ex1_empty", er, 0);

        // A_INSERTION with k=0
        rom[10'h007] = 8'd2;
        run_op(POS_A_INSERTION, 8'd0, 8'd7, 8'd20, 0, kr, lr, er);
        check_val("ex2_k", kr, 21);
        check_val("ex2_l", lr, 22);

        // G_DELETION yielding an empty interval
        rom[10'h203] = 8'd4; rom[10'h203 + 10'd1] = 8'd4;
        run_op(POS_G_DELETION, 8'd4, 8'd4, 8'd8, 0, kr, lr, er);
        check_val("ex3_k", kr, 13);
        check_val("ex3_l", lr, 12);
        check_val("ex3_empty", er, 1);

        // STOP_1 pass-through, then a long downstream stall
        run_op(POS_STOP_1, 8'd3, 8'd9, 8'd77, 0, kr, lr, er);
        check_val("ex4_k", kr, 3);
        check_val("ex4_l", lr, 9);
        run_op(POS_T_INSERTION, 8'd30, 8'd60, 8'd100, 5, kr, lr, er);

        // T_DELETION with k>l (ROM bypass when the skip option is built in)
        run_op(POS_T_DELETION, 8'd9, 8'd5, 8'd40, 0, kr, lr, er);
        if (SKIP_EN) begin
            check_val("ex6_k", kr, 9);
            check_val("ex6_l", lr, 5);
            check_val("ex6_empty", er, 1);
        end

        // Reset during RD_L aborts the operation
        position = POS_C_INSERTION; k_in = 8'd3; l_in = 8'd200; C_in = 8'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("abort_in_rd_l_ce", ce_rom_O, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_ce_rom", ce_rom_O, 0);
        check_val("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check_val("abort_ready_after", in_ready, 1);
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (out_valid || ce_rom_O) seen = 1'b1;
        end
        check_val("abort_no_activity", seen, 0);

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            p = ($urandom_range(0, 2) != 0) ? 5'(12 + $urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0: begin kk = 8'd0; ll = 8'($urandom); end
                1: begin kk = 8'($urandom); ll = kk; end
                2: begin kk = 8'hFF; ll = 8'($urandom); end
                default: begin kk = 8'($urandom); ll = 8'($urandom); end
            endcase
            run_op(p, kk, ll, 8'($urandom), $urandom_range(0, 3), kr, lr, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_kl.md
CALC_KL -- requirements
Module: calc_kl

Interface
REQ-001 clk  in  1  single clock, all state on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  upstream (data-fetch stage) fields valid.
REQ-004 in_ready  out  1  block can accept; high only in IDLE.
REQ-005 position  in  5  operation code, shared config encoding.
REQ-006 addr  in  12  parameter address, passed through.
REQ-007 i_in, z_in, k_in, l_in  in  8 each  search parameters.
REQ-008 d_i_in  in  8  D(i) value, passed through.
REQ-009 read_i_in  in  2  read base, passed through.
REQ-010 C_in  in  8  C(b) for the base in position.
REQ-011 ce_rom_O  out  1  occurrence-ROM enable.
REQ-012 addr_rom_O  out  10  {base[1:0], index[7:0]}; base A=00, C=01, G=10, T=11.
REQ-013 data_rom_O  in  8  O(base,index), valid one cycle after ce_rom_O.
REQ-014 out_valid  out  1 / out_ready  in  1  downstream handshake.
REQ-015 position_out 5, addr_out 12, i_out, z_out, k_out, l_out, d_i_out 8, read_i_out 2  out  registered results.
REQ-016 empty_out  out  1  resulting interval empty (k_out > l_out).

Function
REQ-017 Lookup positions: A/C/G/T_INSERTION and A/C/G/T_DELETION; base taken from position.
REQ-018 Pass-through positions: NONE, STOP_1, STOP_2, all MATCH, all SNP, undefined codes; no ROM access; k_out=k_in, l_out=l_in.
REQ-019 FSM states: IDLE, RD_K, RD_L, CALC, OUT.
REQ-020 IDLE: on in_valid, latch all inputs; go to RD_K for lookup positions, else to OUT.
REQ-021 RD_K: ce_rom_O=1, addr={base,k_in-1}; if k_in==0, ce_rom_O=0 and O_k is forced to 0.
REQ-022 RD_L: ce_rom_O=1, addr={base,l_in}; capture O_k from data_rom_O.
REQ-023 CALC: capture O_l; compute in 9 bits: k'=C+O_k+1, l'=C+O_l.
REQ-024 CALC result mapping: k_out=k'[7:0], l_out=l'[7:0]; empty_out=(k'>l') compared at 9 bits; go to OUT.
REQ-025 OUT: out_valid=1, outputs held stable until out_ready; on out_valid&&out_ready go to IDLE.
REQ-026 Latency: out_valid rises 4 cycles after accept for lookup, 1 cycle after accept for pass-through.
REQ-027 Throughput: one operation in flight; a new accept is possible in the cycle after the OUT handshake.
REQ-028 All other fields pass through unchanged from the latched inputs.
REQ-029 ce_rom_O is 0 in every state except RD_K and RD_L.

Reset
REQ-030 While rst is high, state=IDLE; all outputs read 0, including in_ready.
REQ-031 in_ready=1 from the first cycle after rst deasserts.
REQ-032 rst in any state aborts the operation: no out_valid, ce_rom_O=0 in the next cycle.

Configuration
REQ-033 Macro CALC_KL_SKIP_EMPTY_EN:
- Defined: a lookup position with k_in>l_in goes IDLE->OUT with no ROM reads; k_out=k_in, l_out=l_in, empty_out=1.
- Undefined: all lookup positions follow REQ-021..024.

Structure
REQ-034 Position codes, base encoding, FSM state enum and widths (8-bit params, 10-bit O address) live in the shared config package/header.
REQ-035 One sub-module, kl_adder: combinational C+O_k+1 / C+O_l with the 9-bit compare producing empty.

Verification
REQ-036 C_DELETION, C=10, k=5, l=9, O(C,4)=3, O(C,9)=6 -> addr 0x104 then 0x109; k_out=14, l_out=16, empty_out=0, out_valid 4 cycles after accept.
REQ-037 A_INSERTION, k=0, l=7, C=20, O(A,7)=2 -> only addr 0x007 read; k_out=21, l_out=22.
REQ-038 G_DELETION, O(G,k-1)=O(G,l)=4, C=8 -> k_out=13, l_out=12, empty_out=1.
REQ-039 STOP_1 with k=3, l=9 -> no ce_rom_O; out_valid 1 cycle after accept; k_out=3, l_out=9.
REQ-040 out_ready held low 5 cycles in OUT -> outputs stable, in_ready=0; accept resumes the cycle after the handshake.
REQ-041 rst pulsed during RD_L -> no out_valid; in_ready=1 the cycle after rst falls.
REQ-042 With macro defined: T_DELETION, k=9, l=5 -> no ROM access; empty_out=1 after 1 cycle.
